// File: rtl/bcd_display_controller_if.sv
// rtl/bcd_display_controller_if.sv - scan-side signals between VGA timing, glyph ROM and a HUD digit block
interface bcd_display_controller_if #(
   parameter int PIXEL_DISPLAY_BIT = 9,
   parameter int ADDR_BIT          = 7
);
   logic [PIXEL_DISPLAY_BIT:0] X;
   logic [PIXEL_DISPLAY_BIT:0] Y;
   logic                       number_pixel;
   logic [3:0]                 selected_number;
   logic [ADDR_BIT:0]          glyph_addr;
   logic                       digit_enable;

   modport master (
      output X, Y, number_pixel,
      input  selected_number, glyph_addr, digit_enable
   );

   modport slave (
      input  X, Y, number_pixel,
      output selected_number, glyph_addr, digit_enable
   );
endinterface

// File: rtl/bcd_display_controller.sv
// rtl/bcd_display_controller.sv - HUD BCD up/down counter with two-stage glyph render pipeline
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading-zero cells (LSD always renders).
module bcd_display_controller #(
   parameter int PIXEL_DISPLAY_BIT = 9,
   parameter int DIGITS            = 3,
   parameter int X_START           = 179,
   parameter int Y_START           = 466,
   parameter int GLYPH_W           = 10,
   parameter int GLYPH_H           = 10,
   parameter int CELL_W            = 14,
   parameter int ADDR_BIT          = 7,
   parameter int SATURATE          = 0
) (
   input  logic                  clock_25,
   input  logic                  reset,
   input  logic                  sync_reset,
   input  logic                  tick_up,
   input  logic                  tick_down,
   input  logic                  load_en,
   input  logic [4*DIGITS-1:0]   load_value,
   bcd_display_controller_if.slave scan,
   output logic [4*DIGITS-1:0]   value_bcd,
   output logic                  wrap_flag
);
   localparam int VW = 4 * DIGITS;
   localparam int AW = ADDR_BIT + 1;

   logic [VW-1:0] value_q, value_d;
   logic          wrap_q, wrap_d;
   logic          tick_up_q, tick_down_q;
   logic          up_evt, down_evt;
   logic [3:0]    sel_q, sel_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          hit_q, hit_d;
   logic          en_q, en_d;
   int            x_pos, y_rel;
`ifdef LEADING_ZERO_BLANK_EN
   logic          lead_nz;
`endif

   function automatic logic [VW-1:0] bcd_inc(input logic [VW-1:0] v);
      logic [VW-1:0] r;
      logic          carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [VW-1:0] bcd_dec(input logic [VW-1:0] v);
      logic [VW-1:0] r;
      logic          borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [VW-1:0] bcd_clamp(input logic [VW-1:0] v);
      logic [VW-1:0] r;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
      end
      return r;
   endfunction

   // Simultaneous up and down edges cancel; load overrides both.
   always_comb begin
      up_evt   = tick_up & ~tick_up_q;
      down_evt = tick_down & ~tick_down_q;
      value_d  = value_q;
      wrap_d   = 1'b0;
      if (load_en) begin
         value_d = bcd_clamp(load_value);
      end else if (up_evt && !down_evt) begin
         if (value_q == {DIGITS{4'd9}}) begin
            wrap_d = 1'b1;
            if (SATURATE == 0) value_d = '0;
         end else begin
            value_d = bcd_inc(value_q);
         end
      end else if (down_evt && !up_evt) begin
         if (value_q == '0) begin
            wrap_d = 1'b1;
            if (SATURATE == 0) value_d = {DIGITS{4'd9}};
         end else begin
            value_d = bcd_dec(value_q);
         end
      end
   end

   // Cell hit decoded straight from X/Y each pixel; cells never overlap since CELL_W >= GLYPH_W.
   always_comb begin
      sel_d  = 4'd0;
      addr_d = '0;
      hit_d  = 1'b0;
      x_pos  = int'(scan.X);
      y_rel  = int'(scan.Y) - Y_START;
`ifdef LEADING_ZERO_BLANK_EN
      lead_nz = 1'b0;
`endif
      for (int k = 0; k < DIGITS; k++) begin
`ifdef LEADING_ZERO_BLANK_EN
         lead_nz = lead_nz | (value_q[4*(DIGITS-1-k) +: 4] != 4'd0);
`endif
         if (y_rel >= 0 && y_rel < GLYPH_H &&
             x_pos >= X_START + k*CELL_W && x_pos < X_START + k*CELL_W + GLYPH_W) begin
            sel_d  = value_q[4*(DIGITS-1-k) +: 4];
            addr_d = AW'(y_rel*GLYPH_W + x_pos - (X_START + k*CELL_W));
`ifdef LEADING_ZERO_BLANK_EN
            hit_d  = lead_nz | (k == DIGITS-1);
`else
            hit_d  = 1'b1;
`endif
         end
      end
      en_d = scan.number_pixel & hit_q;
   end

   always_ff @(posedge clock_25 or negedge reset) begin
      if (!reset) begin
         value_q     <= '0;
         wrap_q      <= 1'b0;
         tick_up_q   <= 1'b0;
         tick_down_q <= 1'b0;
         sel_q       <= 4'd0;
         addr_q      <= '0;
         hit_q       <= 1'b0;
         en_q        <= 1'b0;
      end else if (sync_reset) begin
         value_q     <= '0;
         wrap_q      <= 1'b0;
         tick_up_q   <= 1'b0;
         tick_down_q <= 1'b0;
         sel_q       <= 4'd0;
         addr_q      <= '0;
         hit_q       <= 1'b0;
         en_q        <= 1'b0;
      end else begin
         value_q     <= value_d;
         wrap_q      <= wrap_d;
         tick_up_q   <= tick_up;
         tick_down_q <= tick_down;
         sel_q       <= sel_d;
         addr_q      <= addr_d;
         hit_q       <= hit_d;
         en_q        <= en_d;
      end
   end

   assign value_bcd            = value_q;
   assign wrap_flag            = wrap_q;
   assign scan.selected_number = sel_q;
   assign scan.glyph_addr      = addr_q;
   assign scan.digit_enable    = en_q;
endmodule
